// File: rtl/program_load_ctrl.sv
// program_load_ctrl: streams a program image into BRAM, starts the core, times the run until a halt PC, then drains.
// Ports: clock/reset; load_req/load_base/load_count/entry_address command; in_valid/in_data/in_ready image stream;
// mem_* BRAM write port; core_reset/core_start/core_program_address/PC core control; busy/done/run_cycles status.
module program_load_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int MEM_ADDRESS_BITS = 10,
  parameter logic [ADDRESS_BITS-1:0] HALT_PC0 = 32'h000000b0,
  parameter logic [ADDRESS_BITS-1:0] HALT_PC1 = 32'h000000b4,
  parameter int DRAIN_CYCLES = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic load_req,
  input  logic [MEM_ADDRESS_BITS-1:0] load_base,
  input  logic [MEM_ADDRESS_BITS:0] load_count,
  input  logic [ADDRESS_BITS-1:0] entry_address,
  input  logic in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic in_ready,
  output logic mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  output logic [MEM_ADDRESS_BITS-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic core_reset,
  output logic core_start,
  output logic [ADDRESS_BITS-1:0] core_program_address,
  input  logic [ADDRESS_BITS-1:0] PC,
  output logic busy,
  output logic done,
  output logic [31:0] run_cycles
);
  localparam int BE = DATA_WIDTH / 8;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [MEM_ADDRESS_BITS-1:0] base;
  logic [MEM_ADDRESS_BITS:0] count, idx;
  logic [DW-1:0] drain;
  logic fire, go, last, halt, enter_start;
  assign in_ready = state == LOAD;
  assign fire = in_ready & in_valid;
  assign go = load_req && (state == IDLE || state == DONE);
  assign last = fire && idx == count - 1'b1;
  assign halt = PC == HALT_PC0 || PC == HALT_PC1;
  assign enter_start = (go && load_count == '0) || last;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      core_reset <= 1'b1;
      core_start <= 1'b0;
      mem_we <= 1'b0;
      mem_byte_en <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      core_program_address <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      run_cycles <= '0;
      base <= '0;
      count <= '0;
      idx <= '0;
      drain <= '0;
    end else begin
      mem_we <= fire;
      mem_byte_en <= {BE{fire}};
      core_start <= 1'b0;
      if (fire) begin
        mem_addr <= base + idx[MEM_ADDRESS_BITS-1:0];
        mem_wdata <= in_data;
        idx <= idx + 1'b1;
      end
      // outputs for the single START cycle are set on the edge that enters it
      if (enter_start) begin
        core_reset <= 1'b0;
        core_start <= 1'b1;
        run_cycles <= '0;
      end
      case (state)
        IDLE, DONE: if (go) begin
          base <= load_base;
          count <= load_count;
          core_program_address <= entry_address;
          idx <= '0;
          done <= 1'b0;
          busy <= 1'b1;
          state <= load_count == '0 ? START : LOAD;
        end
        LOAD: if (last) state <= START;
        START: state <= RUN;
        RUN: if (halt) begin
          drain <= '0;
          state <= DRAIN;
        end else run_cycles <= &run_cycles ? run_cycles : run_cycles + 1'b1;
        DRAIN: if (drain == DW'(DRAIN_CYCLES - 1)) begin
          state <= DONE;
          done <= 1'b1;
          busy <= 1'b0;
          core_reset <= 1'b1;
        end else drain <= drain + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_load_ctrl.sv
// tb_program_load_ctrl: randomized directed bench for program_load_ctrl against a transaction-level model.
module tb_program_load_ctrl;
  localparam int DRAIN = 50;
  logic clock = 0, reset = 1, load_req = 0, in_valid = 0;
  logic [9:0] load_base = 0;
  logic [10:0] load_count = 0;
  logic [31:0] entry_address = 0, in_data = 0, PC = 0;
  logic in_ready, mem_we, core_reset, core_start, busy, done;
  logic [3:0] mem_byte_en;
  logic [9:0] mem_addr;
  logic [31:0] mem_wdata, core_program_address, run_cycles;
  int errors = 0, checks = 0, cyc = 0;
  program_load_ctrl dut (
    .clock(clock), .reset(reset), .load_req(load_req), .load_base(load_base), .load_count(load_count),
    .entry_address(entry_address), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_byte_en(mem_byte_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_reset(core_reset), .core_start(core_start), .core_program_address(core_program_address),
    .PC(PC), .busy(busy), .done(done), .run_cycles(run_cycles)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  typedef struct {logic [9:0] a; logic [31:0] d; logic [3:0] be; int c;} wr_t;
  wr_t obs[$], exp_q[$];
  int starts, start_cyc;
  always @(negedge clock) begin
    if (mem_we) obs.push_back('{a: mem_addr, d: mem_wdata, be: mem_byte_en, c: cyc});
    if (core_start) begin
      starts++;
      start_cyc = cyc;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic do_load(input int b, input int c, input logic [31:0] e, input int mode, input bit fixed);
    int i = 0, guard = 0, req_cyc;
    obs.delete();
    exp_q.delete();
    starts = 0;
    PC = 32'h10;
    step();
    load_req = 1;
    load_base = b[9:0];
    load_count = c[10:0];
    entry_address = e;
    req_cyc = cyc;
    step();
    load_req = 0;
    chk("done_cleared", done, 0);
    chk("busy_load", busy, 1);
    while (i < c && guard < 4 * c + 100) begin
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? guard % 2 == 1 : 1'($urandom_range(0, 1));
      in_data = fixed ? 32'((i + 1) * 32'h11) : $urandom;
      chk("in_ready_load", in_ready, 1);
      if (in_valid) begin
        exp_q.push_back('{a: 10'((b + i) % 1024), d: in_data, be: 4'hf, c: cyc + 1});
        i++;
      end
      guard++;
      step();
    end
    in_valid = 0;
    chk("beats_done", i, c);
    chk("in_ready_start", in_ready, 0);
    chk("start_high", core_start, 1);
    chk("start_core_reset", core_reset, 0);
    chk("start_entry", core_program_address, e);
    chk("start_run_cycles", run_cycles, 0);
    step();
    chk("start_one_cycle", core_start, 0);
    chk("nwrites", obs.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < obs.size(); k++) begin
      chk("wr_addr", obs[k].a, exp_q[k].a);
      chk("wr_data", obs[k].d, exp_q[k].d);
      chk("wr_be", obs[k].be, exp_q[k].be);
      chk("wr_cycle", obs[k].c, exp_q[k].c);
    end
    chk("start_count", starts, 1);
    chk("start_cycle", start_cyc, c > 0 ? exp_q[exp_q.size() - 1].c : req_cyc + 1);
  endtask
  task automatic run_halt(input int n, input logic [31:0] hpc, input logic [31:0] e, input bit poke);
    PC = 32'h10;
    for (int k = 1; k <= n; k++) begin
      load_req = poke && k == 2;
      load_base = 10'($urandom);
      load_count = 11'($urandom_range(0, 8));
      entry_address = $urandom;
      step();
    end
    load_req = 0;
    chk("run_busy", busy, 1);
    chk("run_core_reset", core_reset, 0);
    chk("run_entry_held", core_program_address, e);
    chk("run_no_write", mem_we, 0);
    PC = hpc;
    step();
    PC = 32'h10;
    chk("halt_run_cycles", run_cycles, n);
    repeat (DRAIN - 1) step();
    chk("drain_not_done", done, 0);
    chk("drain_core_running", core_reset, 0);
    chk("drain_frozen", run_cycles, n);
    step();
    chk("done", done, 1);
    chk("done_busy", busy, 0);
    chk("done_core_reset", core_reset, 1);
    chk("done_run_cycles", run_cycles, n);
    chk("done_entry", core_program_address, e);
  endtask
  initial begin
    logic [31:0] e;
    repeat (3) step();
    chk("rst_core_reset", core_reset, 1);
    chk("rst_start", core_start, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_be", mem_byte_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_entry", core_program_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_run_cycles", run_cycles, 0);
    reset = 0;
    step();
    do_load(0, 4, 0, 0, 1);
    run_halt(20, 32'hb4, 0, 0);
    do_load(0, 4, 0, 1, 1);
    run_halt($urandom_range(3, 60), 32'hb0, 0, 0);
    e = $urandom;
    do_load(1022, 4, e, 2, 0);
    run_halt($urandom_range(3, 60), 32'hb4, e, 0);
    do_load(0, 0, 32'h40, 0, 0);
    run_halt($urandom_range(3, 60), 32'hb0, 32'h40, 0);
    step();
    load_req = 1;
    load_base = 5;
    load_count = 4;
    entry_address = 32'h80;
    step();
    load_req = 0;
    in_valid = 1;
    in_data = $urandom;
    step();
    in_data = $urandom;
    step();
    reset = 1;
    in_data = $urandom;
    step();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_entry", core_program_address, 0);
    reset = 0;
    in_valid = 0;
    step();
    chk("midrst_dropped", mem_we, 0);
    chk("midrst_idle", in_ready, 0);
    e = $urandom;
    do_load($urandom_range(0, 1023), $urandom_range(1, 12), e, 2, 0);
    run_halt($urandom_range(3, 60), 32'hb4, e, 1);
    e = $urandom;
    do_load($urandom_range(0, 1023), 1030, e, 2, 0);
    run_halt($urandom_range(3, 60), 32'hb0, e, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
